// File: rtl/matrix_adder_2x2_serial.sv
// matrix_adder_2x2_serial
// Rebuilds a 2x2 minuend matrix A from a difference matrix C (with borrow
// bits) and the subtrahend matrix B, one element per cycle through a single
// shared 4-bit adder. Each element also gets a flag that is set when the
// carry of the rebuilt addition disagrees with the borrow carried in C.
module matrix_adder_2x2_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] c11,
    input  logic [3:0] c12,
    input  logic [3:0] c21,
    input  logic [3:0] c22,
    input  logic [2:0] b11,
    input  logic [2:0] b12,
    input  logic [2:0] b21,
    input  logic [2:0] b22,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] a11,
    output logic [2:0] a12,
    output logic [2:0] a21,
    output logic [2:0] a22,
    output logic [3:0] err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] idx;
    logic [3:0] c_q   [4];
    logic [2:0] b_q   [4];
    logic [2:0] a_q   [4];
    logic [3:0] err_q;

    logic [3:0] c_sel;
    logic [2:0] b_sel;
    logic [3:0] sum;

    // Zero-extended 3-bit + 3-bit add; bit 3 is the carry that must match
    // the borrow bit supplied with the difference.
    function automatic logic [3:0] add_elem(input logic [3:0] c, input logic [2:0] b);
        return {1'b0, c[2:0]} + {1'b0, b};
    endfunction

    // Element selection for the shared adder, indexed by the CALC step.
    always_comb begin
        c_sel = c_q[idx];
        b_sel = b_q[idx];
        sum   = add_elem(c_sel, b_sel);
    end

    // Control FSM with operand capture and per-element result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 2'd0;
            err_q <= 4'd0;
            for (int k = 0; k < 4; k++) begin
                c_q[k] <= 4'd0;
                b_q[k] <= 3'd0;
                a_q[k] <= 3'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_q[0] <= c11;
                        c_q[1] <= c12;
                        c_q[2] <= c21;
                        c_q[3] <= c22;
                        b_q[0] <= b11;
                        b_q[1] <= b12;
                        b_q[2] <= b21;
                        b_q[3] <= b22;
                        idx    <= 2'd0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    a_q[idx]   <= sum[2:0];
                    err_q[idx] <= sum[3] ^ c_sel[3];
                    idx        <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags come straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign a11 = a_q[0];
    assign a12 = a_q[1];
    assign a21 = a_q[2];
    assign a22 = a_q[3];
    assign err = err_q;

endmodule

// File: tb/tb_matrix_adder_2x2_serial.sv
// Testbench for matrix_adder_2x2_serial: scoreboard of expected results,
// one task per scenario, summary line at the end.
module tb_matrix_adder_2x2_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic [2:0] b11 = '0, b12 = '0, b21 = '0, b22 = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] a11, a12, a21, a22;
    logic [3:0] err;

    typedef struct packed {
        logic [11:0] a;
        logic [3:0]  err;
    } res_t;

    res_t sb[$];
    int   total = 0;
    int   passed = 0;

    matrix_adder_2x2_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c11       (c11),
        .c12       (c12),
        .c21       (c21),
        .c22       (c22),
        .b11       (b11),
        .b12       (b12),
        .b21       (b21),
        .b22       (b22),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a11       (a11),
        .a12       (a12),
        .a21       (a21),
        .a22       (a22),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: integer add, modulo 8 for A, carry compared against borrow.
    function automatic res_t model(input logic [15:0] cp, input logic [11:0] bp);
        res_t r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            int s;
            s = int'(cp[4*k +: 3]) + int'(bp[3*k +: 3]);
            r.a[3*k +: 3] = 3'(s % 8);
            r.err[k]      = (s >= 8) ^ cp[4*k + 3];
        end
        return r;
    endfunction

    function automatic logic [11:0] obs_a();
        return {a22, a21, a12, a11};
    endfunction

    task automatic set_inputs(input logic [15:0] cp, input logic [11:0] bp);
        c11 = cp[3:0];   c12 = cp[7:4];   c21 = cp[11:8]; c22 = cp[15:12];
        b11 = bp[2:0];   b12 = bp[5:3];   b21 = bp[8:6];  b22 = bp[11:9];
    endtask

    task automatic scramble_inputs();
        set_inputs(16'($urandom), 12'($urandom));
    endtask

    // Waits (bounded) for IDLE, presents one pair for one edge, records the
    // expected result, then scrambles the inputs.
    task automatic send(input logic [15:0] cp, input logic [11:0] bp, output logic ok);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        ok = in_ready;
        set_inputs(cp, bp);
        in_valid = 1'b1;
        sb.push_back(model(cp, bp));
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Counts edges until out_valid rises, giving up after 20.
    task automatic wait_out(output int edges, output logic got);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            got = out_valid;
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passed++;
        total++; if (obs_a() !== 12'h000) $display("FAIL reset_a got=%h want=000", obs_a()); else passed++;
        total++; if (err !== 4'b0000) $display("FAIL reset_err got=%b want=0000", err); else passed++;
        in_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_hold_in_ready got=%b want=1", in_ready); else passed++;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_consistent();
        logic ok, got;
        int   edges;
        res_t e, r;
        r.a = {3'd6, 3'd7, 3'd2, 3'd5};
        r.err = 4'b0000;
        send(16'hF0C2, {3'd7, 3'd7, 3'd6, 3'd3}, ok);
        total++; if (in_ready !== 1'b0) $display("FAIL cons_busy in_ready got=%b want=0", in_ready); else passed++;
        wait_out(edges, got);
        total++; if (!got || edges != 4) $display("FAIL cons_latency got=%0d valid=%b want=4", edges, got); else passed++;
        e = sb.pop_front();
        total++; if (e !== r) $display("FAIL cons_model got=%h want=%h", e, r); else passed++;
        total++; if (obs_a() !== r.a) $display("FAIL cons_a got=%h want=%h", obs_a(), r.a); else passed++;
        total++; if (err !== r.err) $display("FAIL cons_err got=%b want=%b", err, r.err); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL cons_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else passed++;
    endtask

    task automatic test_borrow_error();
        logic ok, got;
        int   edges;
        res_t e;
        // c11=1010 b11=1, c12=0011 b12=2, c21=1110 b21=3, c22=0001 b22=7
        send(16'h1E3A, {3'd7, 3'd3, 3'd2, 3'd1}, ok);
        wait_out(edges, got);
        e = sb.pop_front();
        total++; if (!got) $display("FAIL borrow_timeout got=0 want=1"); else passed++;
        total++; if (a11 !== 3'd3 || a22 !== 3'd0)
            $display("FAIL borrow_a a11=%0d a22=%0d want 3/0", a11, a22); else passed++;
        total++; if (err !== 4'b1001) $display("FAIL borrow_err got=%b want=1001", err); else passed++;
        total++; if (obs_a() !== e.a || err !== e.err)
            $display("FAIL borrow_sb got=%h/%b want=%h/%b", obs_a(), err, e.a, e.err); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic        ok, got, held;
        int          edges;
        res_t        e;
        logic [11:0] a_hold;
        logic [3:0]  e_hold;
        send(16'($urandom), 12'($urandom), ok);
        wait_out(edges, got);
        e = sb.pop_front();
        total++; if (!got || obs_a() !== e.a || err !== e.err)
            $display("FAIL bp_result got=%h/%b want=%h/%b", obs_a(), err, e.a, e.err); else passed++;
        a_hold = obs_a();
        e_hold = err;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            scramble_inputs();
            @(posedge clk); #1;
            if (obs_a() !== a_hold || err !== e_hold || out_valid !== 1'b1 || in_ready !== 1'b0) held = 1'b0;
        end
        total++; if (!held) $display("FAIL bp_hold got=%h/%b want=%h/%b", obs_a(), err, a_hold, e_hold); else passed++;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else passed++;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_no_capture in_ready got=%b want=1", in_ready); else passed++;
    endtask

    task automatic test_reset_mid();
        logic ok, got;
        int   edges;
        res_t e;
        send(16'h7777, 12'hFFF, ok);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rmid_ctrl in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else passed++;
        total++; if (obs_a() !== 12'h000 || err !== 4'b0000)
            $display("FAIL rmid_zero got=%h/%b want=000/0000", obs_a(), err); else passed++;
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'h9C5A, {3'd4, 3'd5, 3'd6, 3'd7}, ok);
        wait_out(edges, got);
        e = sb.pop_front();
        total++; if (!got || edges != 4) $display("FAIL rmid_latency got=%0d valid=%b want=4", edges, got); else passed++;
        total++; if (obs_a() !== e.a || err !== e.err)
            $display("FAIL rmid_result got=%h/%b want=%h/%b", obs_a(), err, e.a, e.err); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   sent, recv, cyc, last_cap, bad_gap, bad_res;
        res_t e;
        sent = 0; recv = 0; last_cap = -1; bad_gap = 0; bad_res = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (cyc = 0; cyc < 60 && recv < 4; cyc++) begin
            if (in_ready && sent < 4) begin
                logic [15:0] cp;
                logic [11:0] bp;
                cp = 16'($urandom);
                bp = 12'($urandom);
                set_inputs(cp, bp);
                sb.push_back(model(cp, bp));
                if (last_cap >= 0 && cyc - last_cap != 6) bad_gap++;
                last_cap = cyc;
                sent++;
            end else begin
                scramble_inputs();
                if (sent >= 4) in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (out_valid) begin
                if (sb.size() == 0) bad_res++;
                else begin
                    e = sb.pop_front();
                    if (obs_a() !== e.a || err !== e.err) bad_res++;
                end
                recv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (recv != 4 || sent != 4) $display("FAIL b2b_count recv=%0d sent=%0d want 4/4", recv, sent); else passed++;
        total++; if (bad_gap != 0) $display("FAIL b2b_spacing bad_gaps=%0d want=0", bad_gap); else passed++;
        total++; if (bad_res != 0) $display("FAIL b2b_results bad=%0d want=0", bad_res); else passed++;
    endtask

    initial begin
        test_reset();
        test_consistent();
        test_borrow_error();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/matrix_adder_2x2_serial.md
MATRIX_ADDER_2X2_SERIAL -- requirements
Module: matrix_adder_2x2_serial

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  source presents a difference matrix C and subtrahend matrix B.
REQ-006 in_ready  output  1  block can accept a matrix pair; high exactly when in IDLE.
REQ-007 c11, c12, c21, c22  input  4 each  difference elements; bits [2:0] are (a-b) mod 8, bit [3] is the borrow.
REQ-008 b11, b12, b21, b22  input  3 each  subtrahend elements.
REQ-009 out_valid  output  1  reconstructed matrix A and error flags are valid; high exactly when in DONE.
REQ-010 out_ready  input  1  sink accepts the result.
REQ-011 a11, a12, a21, a22  output  3 each  reconstructed minuend elements, registered.
REQ-012 err  output  4  per-element borrow-consistency error: [0]=11, [1]=12, [2]=21, [3]=22; registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 In IDLE, when in_valid=1 at a rising edge, the block SHALL capture all eight c/b inputs into internal registers, clear the element index to 0, and enter CALC.
REQ-015 Input changes after the capture edge SHALL have no effect on the current result.
REQ-016 In CALC, one element SHALL be processed per cycle, in the order 11, 12, 21, 22, using a single shared 4-bit adder.
REQ-017 For element k: sum = {0,c_k[2:0]} + {0,b_k}; a_k <= sum[2:0]; err[k] <= sum[3] XOR c_k[3].
REQ-018 After processing element 22, the FSM SHALL enter DONE.
REQ-019 Latency: for a capture at edge N, elements are written at edges N+1 through N+4, and out_valid is high starting in the cycle after edge N+4.
REQ-020 In DONE, a11..a22 and err SHALL hold stable while out_ready=0, for any number of cycles.
REQ-021 In DONE, out_ready=1 at an edge SHALL return the FSM to IDLE.
REQ-022 in_valid is ignored in CALC and DONE, including when it is asserted in the same cycle as out_ready.
REQ-023 Minimum period between accepted matrices SHALL be 6 cycles: 1 IDLE + 4 CALC + 1 DONE.
REQ-024 Outside DONE, a/err registers SHALL retain their last values until each element is overwritten; they carry meaning only while out_valid=1.
REQ-025 All arithmetic SHALL be modulo 8 on the a outputs; no saturation and no sticky flags.

Reset
REQ-026 While rst_n=0, the block SHALL force: state=IDLE, index=0, out_valid=0, a11..a22=0, err=0, and all captured registers=0.
REQ-027 in_ready SHALL be 1 during and after reset, since the state is IDLE.
REQ-028 Assertion of rst_n=0 in CALC or DONE SHALL abort the operation immediately, with no partial result presented.
REQ-029 The first capture after reset SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-030 Reset: pulse rst_n low mid-cycle -> out_valid=0, all a=0, err=4'b0000, in_ready=1, with no clock edge required.
REQ-031 Consistent data: capture c11=4'b0010,b11=3; c12=4'b1100,b12=6; c21=4'b0000,b21=7; c22=4'b1111,b22=7 -> after 4 CALC edges, a11=5, a12=2, a21=7, a22=6, err=4'b0000.
REQ-032 Inconsistent borrow: c11=4'b1010,b11=1 and c22=4'b0001,b22=7 (other elements consistent) -> a11=3, a22=0, err=4'b1001.
REQ-033 Backpressure: out_ready=0 for 10 cycles in DONE while toggling in_valid and all inputs -> outputs unchanged, in_ready=0, no new capture; then out_ready=1 for one cycle -> IDLE and in_ready=1.
REQ-034 Reset mid-operation: assert rst_n=0 two edges after capture -> immediate IDLE with zeroed outputs; a new capture after release produces the correct result after 4 edges.
REQ-035 Throughput: hold in_valid=1 and out_ready=1 continuously with distinct matrices -> captures exactly every 6 cycles, and each result matches its own captured pair.
